radar_echo_emulator: RTL

- Responder end of the ARTAU radar interface: watches `radar_pulse_trigger` and returns a `radar_echo` pulse after the round-trip delay of a simulated target.
- Sits beside ICMS in system-level benches and on the FPGA target board, wired back-to-back with ARTAU.
- Holds an internal target distance that can be loaded, and that closes or opens by a signed step after every returned echo, so ARTAU threat detection sees a moving target.

---
 rtl/radar_echo_emulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/radar_echo_emulator.sv
// Radar echo emulator: answers a trigger edge with an echo pulse after the
// round-trip delay of a simulated target whose range moves by a signed step
// after every returned echo.
module radar_echo_emulator #(
  parameter int unsigned M_PER_CYCLE = 150,
  parameter int unsigned ECHO_WIDTH  = 1,
  parameter logic [31:0] MAX_RANGE_M = 32'd300000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        target_present,
  input  logic        load_distance,
  input  logic [31:0] init_distance,
  input  logic [15:0] closing_step,
  output logic        radar_echo,
  output logic        echo_busy,
  output logic [31:0] current_distance,
  output logic [7:0]  pulses_missed,
  output logic [1:0]  emulator_state
);

  localparam logic [32:0] M_STEP = 33'(M_PER_CYCLE);
  localparam logic [7:0]  W_LOAD = 8'(ECHO_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FLIGHT = 2'b01,
    S_ECHO   = 2'b10
  } state_t;

  state_t      state;
  logic        trig_q;
  logic [31:0] flight_d;
  logic [32:0] acc;
  logic [7:0]  width_cnt;
  logic [31:0] distance;
  logic [7:0]  missed;
  logic        echo_q;
  logic        busy_q;

  logic        trig_edge;
  logic        accept;
  logic        missed_inc;
  logic        echo_exit;
  logic [33:0] step_ext;
  logic [33:0] stepped;
  logic [31:0] dist_stepped;

  // Trigger qualification, echo-exit detection and saturating range update
  always_comb begin
    trig_edge  = radar_pulse_trigger & ~trig_q;
    accept     = trig_edge && (state == S_IDLE) && target_present &&
                 (distance <= MAX_RANGE_M);
    missed_inc = trig_edge && !accept;
    echo_exit  = (state == S_ECHO) && (width_cnt == 8'd1);
    step_ext   = {{18{closing_step[15]}}, closing_step};
    // 34-bit difference: bit 33 flags underflow, bit 32 flags overflow
    stepped    = {2'b00, distance} - step_ext;
    if (stepped[33])
      dist_stepped = '0;
    else if (stepped[32])
      dist_stepped = '1;
    else
      dist_stepped = stepped[31:0];
  end

  // Flight/echo state machine with registered echo, busy and counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      trig_q    <= 1'b0;
      flight_d  <= '0;
      acc       <= '0;
      width_cnt <= '0;
      distance  <= '0;
      missed    <= '0;
      echo_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      trig_q <= radar_pulse_trigger;

      if (missed_inc && (missed != 8'hFF))
        missed <= missed + 8'd1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            flight_d <= distance;
            acc      <= M_STEP;
            busy_q   <= 1'b1;
            state    <= S_FLIGHT;
          end
        end
        S_FLIGHT: begin
          if (acc >= {1'b0, flight_d}) begin
            echo_q    <= 1'b1;
            width_cnt <= W_LOAD;
            state     <= S_ECHO;
          end else begin
            acc <= acc + M_STEP;
          end
        end
        S_ECHO: begin
          if (echo_exit) begin
            echo_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            width_cnt <= width_cnt - 8'd1;
          end
        end
        default: begin
          echo_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase

      // An explicit load wins over the post-echo range step
      if (load_distance)
        distance <= init_distance;
      else if (echo_exit)
        distance <= dist_stepped;
    end
  end

  assign radar_echo       = echo_q;
  assign echo_busy        = busy_q;
  assign current_distance = distance;
  assign pulses_missed    = missed;
  assign emulator_state   = state;

endmodule
